// File: rtl/px_threshold_pack.sv
// px_threshold_pack: thresholds filtered pixels, packs mask bits 8 per byte LSB first,
// queues bytes in a 2-entry FIFO and counts foreground pixels per frame.
module px_threshold_pack #(
    parameter int FRAME_PIXELS = 64,
    parameter int CNT_W = $clog2(FRAME_PIXELS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       in_px_data,
    input  logic             in_px_wr,
    output logic             in_px_full,
    input  logic [7:0]       cfg_threshold,
    output logic [7:0]       out_mask_data,
    output logic             out_mask_wr,
    input  logic             out_mask_full,
    output logic [CNT_W-1:0] fg_count,
    output logic             frame_done
);
    logic [CNT_W-1:0] idx, run_cnt, run_next;
    logic [7:0] thr, acc, acc_next;
    logic [7:0] mem [2];
    logic rd_ptr, wr_ptr;
    logic [1:0] count;
    logic accept, fg, last, commit;
    logic [2:0] pos;

    assign in_px_full = count != 2'd2;
    assign accept = in_px_wr & in_px_full;
    // Pixel 0 compares against the live threshold, the rest against the latched copy.
    assign fg = in_px_data >= (idx == '0 ? cfg_threshold : thr);
    assign pos = 3'(idx);
    assign last = idx == CNT_W'(FRAME_PIXELS - 1);
    assign acc_next = acc | (8'(fg) << pos);
    assign commit = accept & (pos == 3'd7 | last);
    assign run_next = run_cnt + CNT_W'(fg);
    assign out_mask_wr = (count != 2'd0) & out_mask_full;
    assign out_mask_data = count != 2'd0 ? mem[rd_ptr] : 8'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            run_cnt    <= '0;
            fg_count   <= '0;
            frame_done <= 1'b0;
            thr        <= 8'd0;
            acc        <= 8'd0;
            mem[0]     <= 8'd0;
            mem[1]     <= 8'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            frame_done <= accept & last;
            count      <= count + 2'(commit) - 2'(out_mask_wr);
            if (commit) begin
                mem[wr_ptr] <= acc_next;
                wr_ptr      <= ~wr_ptr;
            end
            if (out_mask_wr)
                rd_ptr <= ~rd_ptr;
            if (accept) begin
                if (idx == '0)
                    thr <= cfg_threshold;
                acc     <= commit ? 8'd0 : acc_next;
                idx     <= last ? '0 : idx + CNT_W'(1);
                run_cnt <= last ? '0 : run_next;
                if (last)
                    fg_count <= run_next;
            end
        end
    end
endmodule

// File: doc/px_threshold_pack.md
Name: px_threshold_pack

Overview:
- Downstream consumer of the 8-bit median-filter output stream in the soil-segmentation pipeline.
- Compares each filtered pixel against a threshold and packs the binary soil/non-soil decisions 8 pixels per byte, LSB first.
- Emits the packed mask bytes on an output stream with the same write/full handshake.
- Counts foreground pixels per frame and flags frame completion.

Parameters:
- FRAME_PIXELS, 64, pixels per frame (any value >= 1).
- CNT_W, $clog2(FRAME_PIXELS+1) = 7, width of the pixel index and foreground counter.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_px_data  in  8  filtered pixel from the median stage.
- in_px_wr  in  1  pixel valid; a write occurs on any rising edge with in_px_wr=1 and in_px_full=1.
- in_px_full  out  1  high = space available (write permitted); low = stall.
- cfg_threshold  in  8  foreground threshold; pixel is foreground when in_px_data >= threshold.
- out_mask_data  out  8  packed mask byte; bit i = pixel 8k+i of the frame.
- out_mask_wr  out  1  mask byte write strobe.
- out_mask_full  in  1  high = downstream can accept a byte.
- fg_count  out  CNT_W  foreground count of the last completed frame.
- frame_done  out  1  one-cycle pulse on the cycle after the last pixel of a frame is accepted.

Behaviour:
- Reset (reset=0, asynchronous): all state cleared.
  - out_mask_data=0, out_mask_wr=0, fg_count=0, frame_done=0, in_px_full=1.
  - FIFO is emptied, the partial byte and the pixel index are discarded, the latched threshold is cleared to 0.
- Threshold latching:
  - cfg_threshold is sampled when pixel index 0 of a frame is accepted and is used for that pixel.
  - The same value holds for every pixel of the frame; changes to cfg_threshold mid-frame are ignored.
- Packing:
  - A shift/accumulate register holds the bits; the bit position is pixel index mod 8.
  - The byte is committed to the output FIFO when bit 7 is written, or when the last pixel of the frame is accepted.
  - In the last-pixel case the unused high bits are 0.
  - The accumulator clears after each commit.
- Output FIFO: 2 entries.
  - out_mask_wr = FIFO non-empty AND out_mask_full (combinational from registered state).
  - out_mask_data = FIFO head, 0 when empty.
  - The FIFO pops on every cycle where out_mask_wr=1.
  - Push and pop in the same cycle leave the count unchanged.
- Input backpressure:
  - in_px_full = (FIFO count < 2), derived from registers only.
  - No input is accepted while the FIFO is full, so overflow is impossible.
- Latency: commit-triggering pixel accepted at edge N -> byte in FIFO after N -> out_mask_wr high in cycle N+1 if out_mask_full=1 and the FIFO was otherwise empty.
- Frame counter:
  - The pixel index counts 0..FRAME_PIXELS-1 and wraps to 0 after the last pixel.
  - The running foreground counter adds 1 per foreground pixel.
  - On the last pixel, fg_count <= running count including that pixel, the running count clears, and frame_done=1 for exactly one cycle.
  - fg_count holds until the next frame completes.
- Simultaneous events: the last pixel of frame F and the first pixel of frame F+1 can never share a cycle (one pixel per cycle). Frame F+1 starts with a fresh threshold sample and a cleared accumulator.
- Stall: when in_px_wr=1 and in_px_full=0, the pixel is not consumed and no state changes; the producer holds data.
- Reset mid-frame: the partial frame is lost and the next accepted pixel is index 0.

Test Plan:
- FRAME_PIXELS=64, threshold 128, pixels alternating 200,50 (starting 200), out_mask_full=1 -> 8 bytes of 0x55; fg_count=32; frame_done pulses once, one cycle after pixel 63 is accepted.
- Backpressure: out_mask_full=0 while 16 pixels of 255 are streamed -> two 0xFF bytes queued and in_px_full=0 after pixel 16. Raising out_mask_full -> two out_mask_wr pulses, then in_px_full=1, with no pixel loss.
- Threshold change mid-frame: threshold 100 at pixel 0, then 10 from pixel 5, all pixels 50 -> all bytes 0x00 and fg_count=0. Next frame latches 10 -> all 0xFF, fg_count=64.
- Boundary compare: pixel equal to threshold (77 vs 77) -> bit 1; 76 -> bit 0. Threshold 0 -> every pixel foreground.
- FRAME_PIXELS=10, all foreground -> bytes 0xFF then 0x03, fg_count=10, frame_done after pixel 9.
- Reset asserted after 13 pixels -> outputs return to reset values immediately. A fresh 64-pixel frame then produces exactly 8 correct bytes with index restarting at 0.
